// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the immediate stage: opcodes, format codes,
// handshake FSM states and the packed result carried through the pipeline.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R      = 3'd0,
    FMT_I      = 3'd1,
    FMT_S      = 3'd2,
    FMT_B      = 3'd3,
    FMT_U      = 3'd4,
    FMT_J      = 3'd5,
    FMT_ILEGAL = 3'd7
  } formato_t;

  typedef enum logic [1:0] {
    VACIO = 2'd0,
    LLENO = 2'd1,
    SKID  = 2'd2
  } estado_t;

  // Already-decoded entry, so the skid register never needs re-decoding.
  typedef struct packed {
    logic [31:0] inmediato;
    formato_t    formato;
    logic        ilegal;
    logic [31:0] pc;
  } resultado_t;

endpackage

// File: rtl/decodificador_inmediato.sv
// Purely combinational RV32I immediate decoder; U-type keeps the raw 20-bit
// field right-aligned for the downstream 12-bit shifter.
module decodificador_inmediato
  import riscv_pkg::*;
(
  input  logic [31:0] i_instruccion,
  output logic [31:0] o_inmediato,
  output formato_t    o_formato,
  output logic        o_ilegal
);

  always_comb begin
    o_inmediato = '0;
    o_formato   = FMT_ILEGAL;
    o_ilegal    = 1'b1;
    case (i_instruccion[6:0])
      OP_LUI, OP_AUIPC: begin
        o_inmediato = {12'b0, i_instruccion[31:12]};
        o_formato   = FMT_U;
        o_ilegal    = 1'b0;
      end
      OP_JAL: begin
        o_inmediato = {{11{i_instruccion[31]}}, i_instruccion[31], i_instruccion[19:12],
                       i_instruccion[20], i_instruccion[30:21], 1'b0};
        o_formato   = FMT_J;
        o_ilegal    = 1'b0;
      end
      OP_JALR, OP_LOAD, OP_OPIMM: begin
        o_inmediato = {{20{i_instruccion[31]}}, i_instruccion[31:20]};
        o_formato   = FMT_I;
        o_ilegal    = 1'b0;
      end
      OP_STORE: begin
        o_inmediato = {{20{i_instruccion[31]}}, i_instruccion[31:25], i_instruccion[11:7]};
        o_formato   = FMT_S;
        o_ilegal    = 1'b0;
      end
      OP_BRANCH: begin
        o_inmediato = {{19{i_instruccion[31]}}, i_instruccion[31], i_instruccion[7],
                       i_instruccion[30:25], i_instruccion[11:8], 1'b0};
        o_formato   = FMT_B;
        o_ilegal    = 1'b0;
      end
      OP_OP: begin
        o_formato   = FMT_R;
        o_ilegal    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/etapa_inmediato.sv
// Registered immediate-generation stage with valid/ready on both sides and a
// one-entry skid buffer so downstream stalls do not cost throughput.
module etapa_inmediato
  import riscv_pkg::*;
(
  input  logic        Reloj,
  input  logic        Reset,
  input  logic        EntradaValida,
  input  logic [31:0] Instruccion,
  input  logic [31:0] PCEntrada,
  output logic        Listo,
  output logic        SalidaValida,
  input  logic        SalidaListo,
  output logic [31:0] Inmediato,
  output logic [2:0]  Formato,
  output logic        Ilegal,
  output logic [31:0] PCSalida
);

  logic [31:0] w_inmediato;
  formato_t    w_formato;
  logic        w_ilegal;
  resultado_t  w_decod;
  logic        w_entra;
  logic        w_sale;

  resultado_t  r_salida;
  resultado_t  r_skid;
  estado_t     r_estado;

  decodificador_inmediato u_decodificador (
    .i_instruccion (Instruccion),
    .o_inmediato   (w_inmediato),
    .o_formato     (w_formato),
    .o_ilegal      (w_ilegal)
  );

  assign w_decod = '{inmediato: w_inmediato, formato: w_formato, ilegal: w_ilegal, pc: PCEntrada};

  // Listo depends only on state, keeping SalidaListo off the upstream ready path.
  assign Listo        = (r_estado != SKID);
  assign SalidaValida = (r_estado != VACIO);
  assign w_entra      = EntradaValida & Listo;
  assign w_sale       = SalidaValida & SalidaListo;

  always_ff @(posedge Reloj) begin
    if (Reset) begin
      r_estado <= VACIO;
      r_salida <= '0;
      r_skid   <= '0;
    end else begin
      case (r_estado)
        VACIO: begin
          if (w_entra) begin
            r_salida <= w_decod;
            r_estado <= LLENO;
          end
        end
        LLENO: begin
          if (w_sale && w_entra) begin
            r_salida <= w_decod;
          end else if (w_sale) begin
            r_estado <= VACIO;
          end else if (w_entra) begin
            r_skid   <= w_decod;
            r_estado <= SKID;
          end
        end
        // The output entry is older, so it always drains before the skid entry.
        SKID: begin
          if (w_sale) begin
            r_salida <= r_skid;
            r_estado <= LLENO;
          end
        end
        default: r_estado <= VACIO;
      endcase
    end
  end

  assign Inmediato = r_salida.inmediato;
  assign Formato   = r_salida.formato;
  assign Ilegal    = r_salida.ilegal;
  assign PCSalida  = r_salida.pc;

endmodule

// File: tb/tb_etapa_inmediato.sv
// Scoreboard bench for etapa_inmediato: accepted instructions are decoded by a
// plain-arithmetic reference model and matched against the output stream.
module tb_etapa_inmediato;

  logic        Reloj = 1'b0;
  logic        Reset;
  logic        EntradaValida;
  logic [31:0] Instruccion;
  logic [31:0] PCEntrada;
  logic        Listo;
  logic        SalidaValida;
  logic        SalidaListo;
  logic [31:0] Inmediato;
  logic [2:0]  Formato;
  logic        Ilegal;
  logic [31:0] PCSalida;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ilegal;
    logic [31:0] pc;
  } exp_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } stim_t;

  exp_t  expQ[$];
  stim_t stimQ[$];
  int    nChecks = 0;
  int    nPass   = 0;
  bit    offering = 1'b0;
  bit    chkReset = 1'b0;

  etapa_inmediato dut (
    .Reloj         (Reloj),
    .Reset         (Reset),
    .EntradaValida (EntradaValida),
    .Instruccion   (Instruccion),
    .PCEntrada     (PCEntrada),
    .Listo         (Listo),
    .SalidaValida  (SalidaValida),
    .SalidaListo   (SalidaListo),
    .Inmediato     (Inmediato),
    .Formato       (Formato),
    .Ilegal        (Ilegal),
    .PCSalida      (PCSalida)
  );

  always #5 Reloj = ~Reloj;

  // Reference decode written from the ISA field rules with shifts and masks.
  function automatic exp_t refModel(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e.pc     = pc;
    e.imm    = '0;
    e.ilegal = 1'b0;
    e.fmt    = 3'd0;
    case (ins[6:0])
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = ins >> 12; end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = (ins[31] ? 32'hFFF00000 : 32'h0) | (32'(ins[19:12]) << 12)
              | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      end
      7'h67, 7'h03, 7'h13: begin e.fmt = 3'd1; e.imm = 32'($signed(ins) >>> 20); end
      7'h23: begin
        e.fmt = 3'd2;
        e.imm = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
      end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = (ins[31] ? 32'hFFFFF000 : 32'h0) | (32'(ins[7]) << 11)
              | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      end
      7'h33: e.fmt = 3'd0;
      default: begin e.fmt = 3'd7; e.ilegal = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rndInstr();
    logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33};
    logic [31:0] r;
    int          idx;
    r   = $urandom();
    idx = int'($urandom_range(0, 9));
    if (idx == 9) return r;
    return {r[31:7], ops[idx]};
  endfunction

  task automatic checkOutput(input string name, input logic [67:0] act, input logic [67:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Records every accepted instruction just before the edge that transfers it.
  always @(negedge Reloj) begin
    #2;
    if (Reset) expQ.delete();
    else if (EntradaValida && Listo) expQ.push_back(refModel(Instruccion, PCEntrada));
  end

  // Monitor: occupancy-derived Listo/SalidaValida, and the head entry every valid cycle.
  always @(negedge Reloj) begin
    if (Reset === 1'b0) begin
      checkOutput("listo", 68'(Listo), 68'(expQ.size() < 2));
      checkOutput("salidaValida", 68'(SalidaValida), 68'(expQ.size() > 0));
      if (SalidaValida === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedOutput", {Inmediato, Formato, Ilegal, PCSalida}, 68'h0);
        end else begin
          checkOutput("resultado", {Inmediato, Formato, Ilegal, PCSalida}, expQ[0]);
          if (SalidaListo) void'(expQ.pop_front());
        end
      end
    end
  end

  // One clock of stimulus; an offered instruction is held until accepted.
  task automatic applyStimulus(input bit offer, input bit sl);
    bit acc;
    if (!offering && offer && stimQ.size() > 0) begin
      offering    = 1'b1;
      Instruccion = stimQ[0].ins;
      PCEntrada   = stimQ[0].pc;
    end
    if (!offering) begin
      Instruccion = $urandom();
      PCEntrada   = $urandom();
    end
    EntradaValida = offering;
    SalidaListo   = sl;
    @(negedge Reloj);
    if (chkReset) begin
      chkReset = 1'b0;
      checkOutput("resetValida", 68'(SalidaValida), 68'd0);
      checkOutput("resetListo", 68'(Listo), 68'd1);
      checkOutput("resetSalidas", {Inmediato, Formato, Ilegal, PCSalida}, 68'h0);
    end
    #2;
    acc = EntradaValida && Listo && !Reset;
    @(posedge Reloj);
    #1;
    if (acc) begin
      void'(stimQ.pop_front());
      offering = 1'b0;
    end
  endtask

  task automatic applyReset();
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    Reset    = 1'b0;
    chkReset = 1'b1;
  endtask

  initial begin
    int guard;
    Reset         = 1'b1;
    EntradaValida = 1'b0;
    SalidaListo   = 1'b1;
    Instruccion   = '0;
    PCEntrada     = '0;
    @(posedge Reloj);
    #1;
    applyReset();

    $display("[TB] directed decode vectors");
    stimQ.push_back('{ins: 32'h123450B7, pc: 32'h00000100});
    stimQ.push_back('{ins: 32'hFFF00093, pc: 32'h00000104});
    stimQ.push_back('{ins: 32'hFE20AE23, pc: 32'h00000108});
    stimQ.push_back('{ins: 32'h0080006F, pc: 32'h0000010C});
    stimQ.push_back('{ins: 32'h00000000, pc: 32'h00000110});
    repeat (8) applyStimulus(1'b1, 1'b1);

    $display("[TB] backpressure with 3-cycle stall");
    for (int k = 0; k < 4; k++) stimQ.push_back('{ins: rndInstr(), pc: 32'h2000 + 32'(4 * k)});
    repeat (3) applyStimulus(1'b1, 1'b0);
    repeat (8) applyStimulus(1'b1, 1'b1);

    $display("[TB] reset while skid is full");
    for (int k = 0; k < 3; k++) stimQ.push_back('{ins: rndInstr(), pc: 32'h3000 + 32'(4 * k)});
    repeat (3) applyStimulus(1'b1, 1'b0);
    applyReset();
    repeat (4) applyStimulus(1'b1, 1'b1);

    $display("[TB] 16 back-to-back transfers");
    for (int k = 0; k < 16; k++) stimQ.push_back('{ins: rndInstr(), pc: 32'h4000 + 32'(4 * k)});
    repeat (18) applyStimulus(1'b1, 1'b1);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 150; k++) stimQ.push_back('{ins: rndInstr(), pc: {$urandom_range(0, 32'h3FFFFFFF), 2'b00}});
    guard = 0;
    while ((stimQ.size() > 0 || offering) && guard < 3000) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      guard++;
    end
    checkOutput("randomPhaseDone", 68'(stimQ.size()), 68'd0);
    repeat (4) applyStimulus(1'b0, 1'b1);
    checkOutput("drained", 68'(expQ.size()), 68'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/etapa_inmediato.md
# etapa_inmediato

Registered immediate-generation stage between instruction fetch and the execute-side immediate consumers. Decodes each instruction's format and produces its immediate. For U-type (LUI/AUIPC) it outputs the raw 20-bit field right-aligned, to feed the 12-bit logical left shifter directly. Valid/ready handshake on both sides, with a one-entry skid buffer so full throughput survives downstream stalls.

## Interface
- No parameters; data width is fixed at 32.
- Reloj  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high.
- EntradaValida  in  1  upstream holds a valid instruction.
- Instruccion  in  32  RV32I instruction word.
- PCEntrada  in  32  PC of Instruccion.
- Listo  out  1  stage can accept this cycle.
- SalidaValida  out  1  output registers hold a valid result.
- SalidaListo  in  1  downstream accepts this cycle.
- Inmediato  out  32  decoded immediate (U-type: {12'b0, Instruccion[31:12]}).
- Formato  out  3  R=0, I=1, S=2, B=3, U=4, J=5, ILEGAL=7.
- Ilegal  out  1  opcode not in the supported set.
- PCSalida  out  32  PC carried with the result.

## Operation
- Opcode map, Instruccion[6:0]:
  - 0110111/0010111 → U.
  - 1101111 → J.
  - 1100111/0000011/0010011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110011 → R, Inmediato=0.
  - Anything else → ILEGAL, Inmediato=0, Ilegal=1.
- I: sign-extend [31:20].
- S: sign-extend {[31:25],[11:7]}.
- B: sign-extend {[31],[7],[30:25],[11:8],1'b0}.
- J: sign-extend {[31],[19:12],[20],[30:21],1'b0}.
- U: zero-extend [31:12] into bits [19:0]; no sign extension. The shift stage places the field in [31:12].
- Handshake: a transfer in occurs when EntradaValida&Listo; a transfer out occurs when SalidaValida&SalidaListo.
- While SalidaValida=1 and SalidaListo=0, all outputs stay stable.
- FSM states:
  - VACIO: nothing held. In-transfer → LLENO.
  - LLENO: output register valid.
    - Out-transfer and in-transfer → LLENO, new data loaded.
    - Out-transfer only → VACIO.
    - In-transfer only → SKID, data captured in the skid register.
    - Neither → LLENO.
  - SKID: output and skid both valid; Listo=0. Out-transfer → LLENO, skid moves to the output. Otherwise hold.
- Listo = (estado != SKID); it is a pure function of registered state, with no combinational path from SalidaListo.
- SalidaValida = (estado != VACIO).
- Decoding is done combinationally on input and registered together with PC, so the skid register holds already-decoded values.

## Timing
- Latency: 1 cycle. An instruction accepted in cycle N is presented at cycle N+1.
- Throughput: 1 per cycle while SalidaListo=1.
- Reset values (synchronous, same edge, overrides any handshake that cycle): estado=VACIO, Listo=1 after reset, SalidaValida=0, Inmediato=0, Formato=0, Ilegal=0, PCSalida=0, skid cleared.
- Reset mid-operation: held and skid entries are discarded and never presented.
- A stall of k cycles in LLENO with EntradaValida=1 absorbs exactly one extra instruction, then Listo=0 until drained.
- Order is preserved: output always drains before skid; no duplication, no loss.

## Structure
- Shared package `riscv_pkg`: opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OPIMM, OP_STORE, OP_BRANCH, OP_OP), Formato encodings, FSM state encoding.
- One sub-module, `decodificador_inmediato`: purely combinational, Instruccion → {Inmediato, Formato, Ilegal}. The stage instantiates it once on the input side.

## Test plan
- LUI 0x123450B7 accepted at N → cycle N+1: Inmediato=0x00012345, Formato=4, Ilegal=0. Chained into the 12-bit shifter, this yields 0x12345000.
- ADDI 0xFFF00093 → 0xFFFFFFFF, Formato=1. SW 0xFE20AE23 → 0xFFFFFFFC, Formato=2. JAL 0x0080006F → 0x00000008, Formato=5.
- Opcode 0x00000000 → Ilegal=1, Formato=7, Inmediato=0.
- Backpressure: stream of 4 instructions with SalidaListo=0 for 3 cycles.
  - Listo drops after the second is accepted.
  - Outputs stay stable throughout the stall.
  - On release, all 4 emerge in order, PCs intact.
- Reset asserted in SKID state → next cycle SalidaValida=0, Listo=1; neither held instruction is ever output.
- Simultaneous in/out transfers every cycle for 16 instructions → back-to-back SalidaValida=1, one result per cycle, estado stays LLENO.
